sram_mcp2_ctrl: RTL and testbench

Sequencing controller for a 1024x137 single-port, multicycle-path-2 SRAM macro wrapper (RW0 port: addr, en, wmode, wdata, rdata). It arbitrates one read requester and one write requester onto the shared port and holds every access for two cycles so the macro's MCP2 timing constraints hold. It returns read data with fixed latency. It sits between the cache/table pipeline and the SRAM wrapper; one instance per array.

---
 rtl/sram_mcp2_ctrl.sv | 106 ++++++++++
 tb/tb_sram_mcp2_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mcp2_ctrl.sv
// sram_mcp2_ctrl: sequences one read and one write requester onto a single-port MCP2 SRAM macro
// Ports: clock, reset_n (async active-low); rd_valid/rd_addr/rd_ready and
// wr_valid/wr_addr/wr_data/wr_ready request channels; resp_valid/resp_data
// read return (4-cycle latency); init_done; sram_en/sram_wmode/sram_addr/
// sram_wdata/sram_rdata to the RW0 port of the macro wrapper.
// Optional: SRAM_MCP2_CTRL_INIT_EN zero-fills the whole array after reset.
module sram_mcp2_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 137,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  typedef enum logic [1:0] {INIT, IDLE, P0, P1} state_t;
  state_t state;
  logic last_grant;
  logic rd_tag;
  logic rd_pick;
  logic wr_pick;
  logic win;
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
    $error("sram_mcp2_ctrl: DEPTH must equal 2**ADDR_W");
  end
  // last_grant: 1 = write was granted last, so a tie goes to the read
  assign rd_pick  = rd_valid & (~wr_valid | last_grant);
  assign wr_pick  = wr_valid & ~rd_pick;
  // reset_n gating keeps both readies low while reset is held
  assign win      = reset_n & init_done & ((state == IDLE) | (state == P1));
  assign rd_ready = win & rd_pick;
  assign wr_ready = win & wr_pick;
`ifdef SRAM_MCP2_CTRL_INIT_EN
  // low bit selects the hold cycle, upper bits are the address being cleared
  logic [ADDR_W:0] init_cnt;
`else
  assign init_done = 1'b1;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
`ifdef SRAM_MCP2_CTRL_INIT_EN
      state      <= INIT;
      init_done  <= 1'b0;
      init_cnt   <= '0;
`else
      state      <= IDLE;
`endif
      last_grant <= 1'b1;
      rd_tag     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      sram_en    <= 1'b0;
      sram_wmode <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      // a read leaving P1 has its data on sram_rdata during the next cycle
      rd_tag     <= (state == P1) & ~sram_wmode;
      resp_valid <= rd_tag;
      if (rd_tag) resp_data <= sram_rdata;
      case (state)
`ifdef SRAM_MCP2_CTRL_INIT_EN
        INIT: begin
          sram_en    <= 1'b1;
          sram_wmode <= 1'b1;
          sram_addr  <= init_cnt[ADDR_W:1];
          sram_wdata <= '0;
          init_cnt   <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state     <= P1;
            init_done <= 1'b1;
          end
        end
`endif
        P0: state <= P1;
        default: begin
          if (rd_ready | wr_ready) begin
            state      <= P0;
            sram_en    <= 1'b1;
            sram_wmode <= wr_ready;
            sram_addr  <= wr_ready ? wr_addr : rd_addr;
            sram_wdata <= wr_ready ? wr_data : '0;
            last_grant <= wr_ready;
          end else begin
            state   <= IDLE;
            sram_en <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_mcp2_ctrl.sv
// tb_sram_mcp2_ctrl: directed bench with a transaction-level model of sram_mcp2_ctrl
module tb_sram_mcp2_ctrl;
  localparam int AW = 10;
  localparam int DW = 137;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic rd_valid = 1'b0;
  logic wr_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rd_ready, wr_ready, resp_valid, init_done, sram_en, sram_wmode;
  logic [DW-1:0] resp_data, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sram_mcp2_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // power-up content of the array, shared by the macro model and the reference
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 10'h155) ? 137'h1_2345_6789_ABCD
                          : {9'(a), 64'hA5A5_0000_0000_0000 | 64'(a), 64'(a) << 8};
  endfunction

  // macro model: registered read, write on enable
  logic [DW-1:0] mem [1024];
  bit seen [1024];
  always @(posedge clock) if (sram_en) begin
    if (sram_wmode) begin
      mem[sram_addr]  <= sram_wdata;
      seen[sram_addr] <= 1'b1;
    end else sram_rdata <= seen[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, DW'(act), DW'(exp));
  endtask

  // reference model: accesses as a list of acceptances, responses as due dates
  int last_acc = -100;
  bit m_last = 1'b1;
  bit last_wr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wd;
  logic [DW-1:0] ref_mem [1024];
  bit ref_seen [1024];
  logic [DW-1:0] due [int];
  logic [DW-1:0] exp_rdata = '0;
  bit p0, en, rw, ww, rsp;
  always @(negedge clock) begin
    if (!reset_n) begin
      last_acc = -100;
      m_last = 1'b1;
      due.delete();
      exp_rdata = '0;
    end else begin
      p0 = (last_acc == cyc - 1);
      en = p0 || (last_acc == cyc - 2);
      rw = !p0 && rd_valid && (!wr_valid || m_last);
      ww = !p0 && wr_valid && (!rd_valid || !m_last);
      rsp = due.exists(cyc);
      chk1("model rd_ready", rd_ready, rw);
      chk1("model wr_ready", wr_ready, ww);
      chk1("model sram_en", sram_en, en);
      if (en) begin
        chk1("model sram_wmode", sram_wmode, last_wr);
        check("model sram_addr", DW'(sram_addr), DW'(last_addr));
        check("model sram_wdata", sram_wdata, last_wr ? last_wd : '0);
      end
      if (rsp) begin
        exp_rdata = due[cyc];
        due.delete(cyc);
      end
      chk1("model resp_valid", resp_valid, rsp);
      check("model resp_data", resp_data, exp_rdata);
      chk1("model init_done", init_done, 1'b1);
      if (rw || ww) begin
        last_acc = cyc;
        m_last = ww;
        last_wr = ww;
        last_addr = ww ? wr_addr : rd_addr;
        last_wd = wr_data;
        if (ww) begin
          ref_mem[wr_addr] = wr_data;
          ref_seen[wr_addr] = 1'b1;
        end else due[cyc + 4] = ref_seen[rd_addr] ? ref_mem[rd_addr] : init_val(rd_addr);
      end
    end
  end

  // response log for checks made after the fact
  logic [DW-1:0] rlog [$];
  int rcyc [$];
  always @(negedge clock) if (reset_n && resp_valid) begin
    rlog.push_back(resp_data);
    rcyc.push_back(cyc);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clock); while (cyc < c);
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
    t = -1;
    if (wr) begin
      wr_valid = 1'b1;
      wr_addr = a;
      wr_data = d;
    end else begin
      rd_valid = 1'b1;
      rd_addr = a;
    end
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clock);
      if (wr ? wr_ready : rd_ready) t = cyc;
      tick();
    end
    if (wr) wr_valid = 1'b0;
    else rd_valid = 1'b0;
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept timeout: no ready for addr %h, got none, expected ready within 20 cycles", a);
    end
  endtask

  int t, t2, n0;
  int ts [8];
  initial begin
    #1 reset_n = 1'b0;
    rd_valid = 1'b1;
    wr_valid = 1'b1;
    #1;
    chk1("reset rd_ready", rd_ready, 1'b0);
    chk1("reset wr_ready", wr_ready, 1'b0);
    chk1("reset sram_en", sram_en, 1'b0);
    chk1("reset sram_wmode", sram_wmode, 1'b0);
    chk1("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_data", resp_data, '0);
    check("reset sram_addr", DW'(sram_addr), '0);
    check("reset sram_wdata", sram_wdata, '0);
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    @(negedge clock);
    chk1("init_done first cycle", init_done, 1'b1);
    tick();
    // single read of preloaded 0x155
    issue(1'b0, 10'h155, '0, t);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk1("single sram_en", sram_en, k <= 2);
      if (k <= 2) check("single sram_addr", DW'(sram_addr), DW'(10'h155));
      chk1("single resp_valid", resp_valid, k == 4);
      if (k >= 4) check("single resp_data", resp_data, 137'h1_2345_6789_ABCD);
    end
    tick();
    // write then read of the same address
    issue(1'b1, 10'h3FF, 137'h0FF, t);
    issue(1'b0, 10'h3FF, '0, t2);
    check("wr->rd accept gap", DW'(t2 - t), DW'(2));
    wait_cyc(t + 6);
    chk1("wr->rd resp_valid", resp_valid, 1'b1);
    check("wr->rd resp_data", resp_data, 137'h0FF);
    tick(2);
    // contention from reset: grants alternate R, W, R, W
    rd_valid = 1'b1;
    wr_valid = 1'b1;
    rd_addr = 10'h010;
    wr_addr = 10'h020;
    wr_data = 137'h1_5A5A_0000_C3C3;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk1("contend rd_ready", rd_ready, (i % 4) == 0);
      chk1("contend wr_ready", wr_ready, (i % 4) == 2);
    end
    tick();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    tick(8);
    // streaming reads of addresses 0..7
    rlog.delete();
    rcyc.delete();
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(i), '0, ts[i]);
    check("stream accept spacing", DW'(ts[7] - ts[0]), DW'(14));
    wait_cyc(ts[7] + 6);
    check("stream response count", DW'(rlog.size()), DW'(8));
    if (rlog.size() == 8) begin
      check("stream first resp cycle", DW'(rcyc[0] - ts[0]), DW'(4));
      check("stream resp spacing", DW'(rcyc[1] - rcyc[0]), DW'(2));
      check("stream data addr 0", rlog[0], {9'd0, 64'hA5A5_0000_0000_0000, 64'h0});
      check("stream data addr 3", rlog[3], {9'd3, 64'hA5A5_0000_0000_0003, 64'h300});
    end
    tick();
    // reset during the P1 of a read
    issue(1'b0, 10'h155, '0, t);
    n0 = rlog.size();
    @(posedge clock);
    #1 reset_n = 1'b0;
    rd_valid = 1'b1;
    #1;
    chk1("midreset sram_en", sram_en, 1'b0);
    chk1("midreset rd_ready", rd_ready, 1'b0);
    chk1("midreset resp_valid", resp_valid, 1'b0);
    check("midreset resp_data", resp_data, '0);
    check("midreset sram_addr", DW'(sram_addr), '0);
    rd_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    wait_cyc(t + 8);
    check("midreset no response", DW'(rlog.size() - n0), '0);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
